uart_msg_tx: RTL and testbench

- Parametrised message transmitter: holds a writable message buffer of MSG_DEPTH characters and serialises it over a UART line.
- Generalises the fixed "hello world\n" sender: configurable width, depth, baud divider and stop bits.
- Adds start/abort/repeat control, a terminator character and a done pulse.
- Sits between a host/control FSM and the board TX pin.

---
 rtl/uart_msg_pkg.sv | 33 +++
 rtl/uart_msg_if.sv | 35 +++
 rtl/uart_msg_tx_shifter.sv | 88 ++++++++
 rtl/uart_msg_tx.sv | 158 +++++++++++++++
 tb/tb_uart_msg_tx.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_msg_pkg.sv
// uart_msg_pkg
// Shared definitions for the UART message transmitter:
//   - state_t           : message FSM states (IDLE, LOAD, SHIFT, NEXT, GAP)
//   - DEFAULT_TERM_CHAR : default end-of-message character (newline)
//   - frame_bits()      : number of bit periods in one character frame
//   - frame_cycles()    : length of one character frame in clock cycles
// Optional feature macro: UART_MSG_PARITY_EN adds one even-parity bit per frame.
package uart_msg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        NEXT,
        GAP
    } state_t;

    localparam logic [7:0] DEFAULT_TERM_CHAR = 8'h0A;

    // Start bit + data bits + optional parity bit + stop bits.
    function automatic int frame_bits(input int data_w, input int stop_bits);
`ifdef UART_MSG_PARITY_EN
        return 2 + data_w + stop_bits;
`else
        return 1 + data_w + stop_bits;
`endif
    endfunction

    function automatic int frame_cycles(input int data_w, input int stop_bits, input int clk_div);
        return clk_div * frame_bits(data_w, stop_bits);
    endfunction

endpackage

// File: rtl/uart_msg_if.sv
// uart_msg_if
// Host-side bundle of the UART message transmitter.
//   master : host / control FSM (drives buffer writes and control, reads status)
//   slave  : uart_msg_tx (accepts writes and control, drives line and status)
// Signals:
//   wr_en, wr_addr, wr_data : message buffer write port
//   start, repeat_en, abort : message control
//   uart_tx_data            : serial line, idle high
//   uart_busy, done         : message status
//   cur_char                : character currently being shifted
interface uart_msg_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              repeat_en;
    logic              abort;
    logic              uart_tx_data;
    logic              uart_busy;
    logic              done;
    logic [DATA_W-1:0] cur_char;

    modport master (
        output wr_en, wr_addr, wr_data, start, repeat_en, abort,
        input  uart_tx_data, uart_busy, done, cur_char
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, repeat_en, abort,
        output uart_tx_data, uart_busy, done, cur_char
    );
endinterface

// File: rtl/uart_msg_tx_shifter.sv
// uart_bit_shifter
// Serialises one character as a UART frame: start bit, DATA_W data bits LSB
// first, optional even-parity bit, STOP_BITS stop bits; each bit lasts CLK_DIV
// clock cycles.
// Ports:
//   RST_clk      in  clock, rising edge
//   RST_rst      in  asynchronous active-high reset (line forced high)
//   load         in  request to send 'data'; taken only while ready
//   data         in  character to send
//   ready        out shifter idle, a load will be accepted
//   frame_ending out high in the second-to-last cycle of the final stop bit
//   tx           out serial line, idle high
// Optional feature macro: UART_MSG_PARITY_EN inserts the parity bit.
module uart_bit_shifter
    import uart_msg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 434,
    parameter int STOP_BITS = 1
) (
    input  logic              RST_clk,
    input  logic              RST_rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              frame_ending,
    output logic              tx
);
    localparam int NBITS  = frame_bits(DATA_W, STOP_BITS);
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 4);

    localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRELAST = BAUD_W'(CLK_DIV - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(NBITS - 1);

    logic [NBITS-1:0]  frame;
    logic [NBITS-2:0]  shreg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              active;

`ifdef UART_MSG_PARITY_EN
    assign frame = {{STOP_BITS{1'b1}}, ^data, data, 1'b0};
`else
    assign frame = {{STOP_BITS{1'b1}}, data, 1'b0};
`endif

    assign ready = ~active;

    // Raised one cycle early so the parent can decide the next step while the
    // last stop bit is still on the line, leaving a single idle cycle between
    // back-to-back characters.
    assign frame_ending = active && (bit_cnt == BIT_LAST) && (baud_cnt == BAUD_PRELAST);

    // The start bit goes straight to tx on load; the remaining bits wait in
    // shreg and are shifted out LSB first at every bit boundary.
    always_ff @(posedge RST_clk or posedge RST_rst) begin
        if (RST_rst) begin
            active   <= 1'b0;
            tx       <= 1'b1;
            shreg    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!active) begin
            if (load) begin
                active   <= 1'b1;
                tx       <= 1'b0;
                shreg    <= frame[NBITS-1:1];
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
                active <= 1'b0;
                tx     <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[NBITS-2:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_msg_tx.sv
// uart_msg_tx
// Message transmitter: holds a MSG_DEPTH-entry character buffer written by the
// host and sends it over a UART line, stopping at TERM_CHAR or the last entry.
// Supports abort after the current character and endless repeat with a
// GAP_CYCLES idle gap between messages; done pulses once per finished message.
// Ports:
//   RST_clk in  clock, rising edge
//   RST_rst in  asynchronous active-high reset
//   bus     uart_msg_if.slave : buffer write port, start/repeat_en/abort,
//           uart_tx_data, uart_busy, done, cur_char
// Optional feature macro: UART_MSG_PARITY_EN adds an even-parity bit per frame.
module uart_msg_tx
    import uart_msg_pkg::*;
#(
    parameter int         DATA_W     = 8,
    parameter int         MSG_DEPTH  = 16,
    parameter int         CLK_DIV    = 434,
    parameter int         STOP_BITS  = 1,
    parameter logic [7:0] TERM_CHAR  = DEFAULT_TERM_CHAR,
    parameter int         GAP_CYCLES = 1000
) (
    input  logic       RST_clk,
    input  logic       RST_rst,
    uart_msg_if.slave  bus
);
    localparam int ADDR_W = $clog2(MSG_DEPTH);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(MSG_DEPTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [DATA_W-1:0] TERM     = TERM_CHAR[DATA_W-1:0];

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] cur_char_q;
    logic              busy_q;
    logic              done_q;
    logic              abort_seen;

    logic [DATA_W-1:0] msg_buf [MSG_DEPTH];

    logic              wr_ok;
    logic [DATA_W-1:0] first_char;
    logic              aborting;
    logic              msg_end;
    logic              shift_load;
    logic              shift_ready;
    logic              frame_ending;
    logic              tx;

    assign wr_ok      = bus.wr_en && (state == IDLE || state == GAP);
    assign aborting   = abort_seen || bus.abort;
    assign msg_end    = (cur_char_q == TERM) || (ptr == PTR_LAST) || aborting;
    assign shift_load = (state == LOAD);

    // A write to entry 0 in the same cycle that a message (re)starts must be
    // seen by that message, so bypass the buffer for the first character.
    assign first_char = (wr_ok && bus.wr_addr == '0) ? bus.wr_data : msg_buf[0];

    // Buffer contents deliberately survive reset.
    always_ff @(posedge RST_clk) begin
        if (wr_ok) begin
            msg_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Message FSM. abort is sticky from any non-IDLE state so it is honoured at
    // the next character boundary; every path back to IDLE clears it.
    always_ff @(posedge RST_clk or posedge RST_rst) begin
        if (RST_rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gap_cnt    <= '0;
            cur_char_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_seen <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != IDLE && bus.abort) begin
                abort_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        cur_char_q <= first_char;
                    end
                end
                LOAD: begin
                    if (shift_ready) begin
                        state  <= SHIFT;
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (frame_ending) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (!msg_end) begin
                        state      <= LOAD;
                        ptr        <= ptr + 1'b1;
                        cur_char_q <= msg_buf[ptr + 1'b1];
                    end else if (bus.repeat_en && !aborting) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end else begin
                        state      <= IDLE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        abort_seen <= 1'b0;
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state      <= IDLE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        abort_seen <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        cur_char_q <= first_char;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    uart_bit_shifter #(
        .DATA_W    (DATA_W),
        .CLK_DIV   (CLK_DIV),
        .STOP_BITS (STOP_BITS)
    ) u_shifter (
        .RST_clk      (RST_clk),
        .RST_rst      (RST_rst),
        .load         (shift_load),
        .data         (cur_char_q),
        .ready        (shift_ready),
        .frame_ending (frame_ending),
        .tx           (tx)
    );

    assign bus.uart_tx_data = tx;
    assign bus.uart_busy    = busy_q;
    assign bus.done         = done_q;
    assign bus.cur_char     = cur_char_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// tb_uart_msg_tx
// Self-checking bench for uart_msg_tx with CLK_DIV=4, DATA_W=8, STOP_BITS=1,
// GAP_CYCLES=8, MSG_DEPTH=16. The line, busy and done are recorded every cycle
// and decoded afterwards with an independent UART receiver model.
// Honours UART_MSG_PARITY_EN for the expected frame layout.
module tb_uart_msg_tx;

    localparam int DATA_W     = 8;
    localparam int MSG_DEPTH  = 16;
    localparam int ADDR_W     = 4;
    localparam int CLK_DIV    = 4;
    localparam int STOP_BITS  = 1;
    localparam int GAP_CYCLES = 8;
`ifdef UART_MSG_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NB    = 1 + DATA_W + PAR_BITS + STOP_BITS;
    localparam int FRAME = CLK_DIV * NB;
    localparam int PITCH = FRAME + 1;
    localparam int HIST  = 16384;

    typedef struct packed {
        logic [4:0]       n_wr;
        logic [15:0][7:0] data;
        logic [4:0]       n_exp;
    } vec_t;

    logic RST_clk = 1'b0;
    logic RST_rst;

    uart_msg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    uart_msg_tx #(
        .DATA_W     (DATA_W),
        .MSG_DEPTH  (MSG_DEPTH),
        .CLK_DIV    (CLK_DIV),
        .STOP_BITS  (STOP_BITS),
        .TERM_CHAR  (8'h0A),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .RST_clk (RST_clk),
        .RST_rst (RST_rst),
        .bus     (bus)
    );

    always #5 RST_clk = ~RST_clk;

    int   cyc = 0;
    logic tx_hist   [HIST];
    logic busy_hist [HIST];
    logic done_hist [HIST];

    int   n_checks = 0;
    int   n_pass   = 0;

    int         dec_cnt;
    logic [7:0] dec_chars  [64];
    int         dec_starts [64];

    vec_t vecs [4];

    always @(posedge RST_clk) cyc <= cyc + 1;

    always @(negedge RST_clk) begin
        if (cyc < HIST) begin
            tx_hist[cyc]   <= bus.uart_tx_data;
            busy_hist[cyc] <= bus.uart_busy;
            done_hist[cyc] <= bus.done;
        end
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge RST_clk);
    endtask

    task automatic wait_cycle(input int t);
        while (cyc < t) @(negedge RST_clk);
    endtask

    function automatic logic [15:0][7:0] pk(input string s);
        logic [15:0][7:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < 16; i++) r[i] = s[i];
        return r;
    endfunction

    function automatic vec_t mk_vec(input string s, input int n_wr, input int n_exp);
        vec_t v;
        v.n_wr  = 5'(n_wr);
        v.data  = pk(s);
        v.n_exp = 5'(n_exp);
        return v;
    endfunction

    task automatic write_word(input int addr, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_W'(addr);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic start_msg(output int t_n);
        bus.start = 1'b1;
        t_n = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    // Independent UART receiver: finds start bits in the recorded line and
    // samples each bit in the middle of its period.
    task automatic decode(input int t_from, input int t_to);
        int         t;
        int         s;
        logic [7:0] ch;
        t = t_from;
        dec_cnt = 0;
        while (t <= t_to) begin
            if (tx_hist[t] === 1'b0 && dec_cnt < 64) begin
                s  = t;
                ch = '0;
                for (int b = 0; b < DATA_W; b++) ch[b] = tx_hist[s + CLK_DIV * (1 + b) + CLK_DIV / 2];
`ifdef UART_MSG_PARITY_EN
                check_eq("parity_bit", 32'(tx_hist[s + CLK_DIV * (1 + DATA_W) + CLK_DIV / 2]), 32'(^ch));
`endif
                for (int j = 0; j < STOP_BITS; j++)
                    check_eq("stop_bit", 32'(tx_hist[s + CLK_DIV * (1 + DATA_W + PAR_BITS + j) + CLK_DIV / 2]), 1);
                dec_chars[dec_cnt]  = ch;
                dec_starts[dec_cnt] = s;
                dec_cnt++;
                t = s + FRAME;
            end else begin
                t++;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int t_n);
        for (int i = 0; i < int'(v.n_wr); i++) write_word(i, v.data[i]);
        start_msg(t_n);
    endtask

    // Checks a plain (non-repeating, non-aborted) message started at t_n.
    task automatic checkOutput(input int t_n, input int n_exp, input logic [15:0][7:0] exp_chars);
        int t_done;
        int n_done;
        t_done = t_n + 1 + n_exp * PITCH;
        n_done = 0;
        wait_cycle(t_done + 30);
        decode(t_n + 1, t_done + 25);
        check_eq("char_count", dec_cnt, n_exp);
        for (int k = 0; k < n_exp && k < dec_cnt; k++) begin
            check_eq($sformatf("char%0d", k), 32'(dec_chars[k]), 32'(exp_chars[k]));
            check_eq($sformatf("start_cycle%0d", k), dec_starts[k], t_n + 2 + k * PITCH);
        end
        check_eq("busy_before_first_bit", 32'(busy_hist[t_n + 1]), 0);
        check_eq("busy_at_first_bit", 32'(busy_hist[t_n + 2]), 1);
        check_eq("busy_last_stop", 32'(busy_hist[t_done - 1]), 1);
        check_eq("busy_after_done", 32'(busy_hist[t_done]), 0);
        check_eq("done_at_end", 32'(done_hist[t_done]), 1);
        for (int t = t_n; t <= t_done + 25; t++) n_done += int'(done_hist[t]);
        check_eq("done_pulses", n_done, 1);
    endtask

    initial begin
        int t_n;
        int s_nl;
        int s_a2;
        int s_b2;
        int g;
        int n_done;

        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.repeat_en = 1'b0;
        bus.abort     = 1'b0;
        RST_rst       = 1'b1;

        vecs[0] = mk_vec("hi\n", 3, 3);
        vecs[1] = mk_vec("AAAAAAAAAAAAAAAA", 16, 16);
        vecs[2] = mk_vec("\n", 1, 1);
        vecs[3] = mk_vec("Q\nRS", 4, 2);

        repeat (3) tick();
        check_eq("reset_tx", 32'(bus.uart_tx_data), 1);
        check_eq("reset_busy", 32'(bus.uart_busy), 0);
        check_eq("reset_done", 32'(bus.done), 0);
        check_eq("reset_cur_char", 32'(bus.cur_char), 0);
        RST_rst = 1'b0;
        repeat (2) tick();

        $display("[TB] table-driven messages");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], t_n);
            checkOutput(t_n, int'(vecs[i].n_exp), vecs[i].data);
        end

        $display("[TB] repeat then abort mid-character");
        write_word(0, 8'h61);
        write_word(1, 8'h62);
        write_word(2, 8'h0A);
        bus.repeat_en = 1'b1;
        start_msg(t_n);
        s_nl = t_n + 2 + 2 * PITCH;
        s_a2 = s_nl + FRAME + GAP_CYCLES + 1;
        s_b2 = s_a2 + PITCH;
        wait_cycle(s_b2 + FRAME / 2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        wait_cycle(s_b2 + FRAME + 30);
        bus.repeat_en = 1'b0;
        decode(t_n + 1, s_b2 + FRAME + 25);
        check_eq("rpt_char_count", dec_cnt, 5);
        if (dec_cnt == 5) begin
            check_eq("rpt_char3", 32'(dec_chars[3]), 32'h61);
            check_eq("rpt_char4", 32'(dec_chars[4]), 32'h62);
            check_eq("rpt_restart_cycle", dec_starts[3], s_a2);
            check_eq("rpt_char4_cycle", dec_starts[4], s_b2);
        end
        check_eq("rpt_busy_in_gap", 32'(busy_hist[s_nl + FRAME + 4]), 1);
        check_eq("rpt_done_after_abort", 32'(done_hist[s_b2 + FRAME]), 1);
        check_eq("rpt_busy_after_abort", 32'(busy_hist[s_b2 + FRAME]), 0);
        n_done = 0;
        for (int t = t_n; t <= s_b2 + FRAME + 25; t++) n_done += int'(done_hist[t]);
        check_eq("rpt_done_pulses", n_done, 1);

        $display("[TB] abort during gap");
        write_word(0, 8'h0A);
        bus.repeat_en = 1'b1;
        start_msg(t_n);
        g = t_n + 2 + FRAME + 3;
        wait_cycle(g);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.repeat_en = 1'b0;
        wait_cycle(g + 40);
        decode(t_n + 1, g + 35);
        check_eq("gap_abort_char_count", dec_cnt, 1);
        check_eq("gap_abort_busy_before", 32'(busy_hist[g]), 1);
        check_eq("gap_abort_done", 32'(done_hist[g + 1]), 1);
        check_eq("gap_abort_busy_after", 32'(busy_hist[g + 1]), 0);

        $display("[TB] reset in the middle of a frame");
        write_word(0, 8'h68);
        write_word(1, 8'h69);
        write_word(2, 8'h0A);
        start_msg(t_n);
        wait_cycle(t_n + 2 + 20);
        #2 RST_rst = 1'b1;
        #1;
        check_eq("midreset_tx", 32'(bus.uart_tx_data), 1);
        check_eq("midreset_busy", 32'(bus.uart_busy), 0);
        check_eq("midreset_cur_char", 32'(bus.cur_char), 0);
        repeat (2) tick();
        RST_rst = 1'b0;
        tick();
        start_msg(t_n);
        checkOutput(t_n, 3, pk("hi\n"));

        $display("[TB] writes while shifting and same-cycle events");
        start_msg(t_n);
        wait_cycle(t_n + 10);
        check_eq("cur_char_shifting", 32'(bus.cur_char), 32'h68);
        write_word(1, 8'h5A);
        checkOutput(t_n, 3, pk("hi\n"));
        write_word(1, 8'h5A);
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = 8'h48;
        bus.abort   = 1'b1;
        start_msg(t_n);
        bus.wr_en   = 1'b0;
        bus.abort   = 1'b0;
        check_eq("cur_char_bypass", 32'(bus.cur_char), 32'h48);
        checkOutput(t_n, 3, pk("HZ\n"));

`ifdef UART_MSG_PARITY_EN
        $display("[TB] parity frame");
        write_word(0, 8'h07);
        write_word(1, 8'h0A);
        start_msg(t_n);
        checkOutput(t_n, 2, pk("\x07\n"));
        check_eq("parity_0x07", 32'(tx_hist[t_n + 2 + CLK_DIV * (1 + DATA_W) + CLK_DIV / 2]), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
